// File: rtl/hdlc_rx_deframer_if.sv
// Serial line in, frame/byte events out, for the HDLC receive bit-level front end.
// The master side drives the line; the slave side is the deframer.
interface hdlc_rx_deframer_if;
    logic       RxEN;
    logic       Rx;
    logic       Rx_FlagDetect;
    logic       Rx_AbortDetect;
    logic       Rx_ValidFrame;
    logic [7:0] Rx_Data;
    logic       Rx_NewByte;
    logic       Rx_EoF;
    logic       Rx_FrameError;
    logic       Rx_Overflow;
    logic [7:0] Rx_FrameSize;

    modport master (
        output RxEN,
        output Rx,
        input  Rx_FlagDetect,
        input  Rx_AbortDetect,
        input  Rx_ValidFrame,
        input  Rx_Data,
        input  Rx_NewByte,
        input  Rx_EoF,
        input  Rx_FrameError,
        input  Rx_Overflow,
        input  Rx_FrameSize
    );

    modport slave (
        input  RxEN,
        input  Rx,
        output Rx_FlagDetect,
        output Rx_AbortDetect,
        output Rx_ValidFrame,
        output Rx_Data,
        output Rx_NewByte,
        output Rx_EoF,
        output Rx_FrameError,
        output Rx_Overflow,
        output Rx_FrameSize
    );
endinterface

// File: rtl/hdlc_rx_deframer.sv
// HDLC receive deframer: flag/abort detection, zero-bit removal and LSB-first
// byte assembly, with frame open/close tracking and overflow limiting.
module hdlc_rx_deframer #(
    parameter int MAX_FRAME_BYTES = 128
) (
    input  logic                Clk,
    input  logic                Rst,
    hdlc_rx_deframer_if.slave   rx_if
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_OPEN,
        ST_FRAME
    } state_t;

    localparam logic [7:0] MAX_BYTES = 8'(MAX_FRAME_BYTES);

    state_t     state_q, state_d;
    logic [7:0] window_q, window_d;
    logic [7:0] mask_q, mask_d;
    logic       fresh_q, fresh_d;
    logic [2:0] ones_q, ones_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [6:0] shift_q, shift_d;
    logic [7:0] data_q, data_d;
    logic [7:0] size_q, size_d;
    logic       ovf_done_q, ovf_done_d;
    logic       flag_q, flag_d;
    logic       abort_q, abort_d;
    logic       valid_q, valid_d;
    logic       new_byte_q, new_byte_d;
    logic       eof_q, eof_d;
    logic       err_q, err_d;
    logic       ovf_q, ovf_d;
    logic       eof_pend_q, eof_pend_d;
    logic       err_pend_q, err_pend_d;

    logic pat_flag;
    logic pat_abort;
    logic flag_ev;
    logic abort_ev;
    logic proc_bit;
    logic proc_en;
    logic keep_bit;

    // A pattern only counts if the window was shifted on the previous edge,
    // so a pattern frozen in the window while disabled cannot fire on re-enable.
    assign pat_flag  = (window_q == 8'h7E);
    assign pat_abort = (window_q == 8'h7F);
    assign flag_ev   = rx_if.RxEN & fresh_q & pat_flag;
    assign abort_ev  = rx_if.RxEN & fresh_q & pat_abort;
    assign proc_bit  = window_q[7];
    assign proc_en   = rx_if.RxEN & mask_q[7] & ~pat_flag & ~pat_abort & (state_q != ST_IDLE);

    always_comb begin
        state_d     = state_q;
        window_d    = window_q;
        mask_d      = mask_q;
        fresh_d     = rx_if.RxEN;
        ones_d      = ones_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        data_d      = data_q;
        size_d      = size_q;
        ovf_done_d  = ovf_done_q;
        flag_d      = 1'b0;
        abort_d     = 1'b0;
        valid_d     = valid_q;
        new_byte_d  = 1'b0;
        ovf_d       = 1'b0;
        eof_pend_d  = 1'b0;
        err_pend_d  = 1'b0;
        eof_d       = eof_pend_q;
        err_d       = err_pend_q;
        keep_bit    = 1'b0;

        if (!rx_if.RxEN) begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
        end else begin
            window_d = {window_q[6:0], rx_if.Rx};
            // Bits that made up a flag or abort must never reach the data path.
            mask_d   = (pat_flag | pat_abort) ? 8'h01 : {mask_q[6:0], 1'b1};

            if (flag_ev) begin
                flag_d = 1'b1;
                if (state_q == ST_FRAME) begin
                    eof_pend_d = 1'b1;
                    err_pend_d = (bit_cnt_q != 3'd0);
                end
                state_d    = ST_OPEN;
                valid_d    = 1'b0;
                ones_d     = 3'd0;
                bit_cnt_d  = 3'd0;
                ovf_done_d = 1'b0;
            end else if (abort_ev) begin
                abort_d = 1'b1;
                if (state_q == ST_FRAME) begin
                    eof_pend_d = 1'b1;
                end
                state_d    = ST_IDLE;
                valid_d    = 1'b0;
                ones_d     = 3'd0;
                bit_cnt_d  = 3'd0;
                ovf_done_d = 1'b0;
            end else if (proc_en) begin
                if (proc_bit) begin
                    ones_d   = (ones_q == 3'd7) ? ones_q : ones_q + 3'd1;
                    keep_bit = 1'b1;
                end else begin
                    ones_d   = 3'd0;
                    keep_bit = (ones_q != 3'd5);
                end

                if (keep_bit) begin
                    shift_d   = {proc_bit, shift_q[6:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        if (state_q == ST_OPEN) begin
                            new_byte_d = 1'b1;
                            data_d     = {proc_bit, shift_q};
                            size_d     = 8'd1;
                            state_d    = ST_FRAME;
                            valid_d    = 1'b1;
                        end else if (size_q < MAX_BYTES) begin
                            new_byte_d = 1'b1;
                            data_d     = {proc_bit, shift_q};
                            size_d     = size_q + 8'd1;
                        end else if (!ovf_done_q) begin
                            ovf_d      = 1'b1;
                            ovf_done_d = 1'b1;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q    <= ST_IDLE;
            window_q   <= 8'hFF;
            mask_q     <= 8'h00;
            fresh_q    <= 1'b0;
            ones_q     <= 3'd0;
            bit_cnt_q  <= 3'd0;
            shift_q    <= 7'd0;
            data_q     <= 8'd0;
            size_q     <= 8'd0;
            ovf_done_q <= 1'b0;
            flag_q     <= 1'b0;
            abort_q    <= 1'b0;
            valid_q    <= 1'b0;
            new_byte_q <= 1'b0;
            eof_q      <= 1'b0;
            err_q      <= 1'b0;
            ovf_q      <= 1'b0;
            eof_pend_q <= 1'b0;
            err_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            window_q   <= window_d;
            mask_q     <= mask_d;
            fresh_q    <= fresh_d;
            ones_q     <= ones_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            data_q     <= data_d;
            size_q     <= size_d;
            ovf_done_q <= ovf_done_d;
            flag_q     <= flag_d;
            abort_q    <= abort_d;
            valid_q    <= valid_d;
            new_byte_q <= new_byte_d;
            eof_q      <= eof_d;
            err_q      <= err_d;
            ovf_q      <= ovf_d;
            eof_pend_q <= eof_pend_d;
            err_pend_q <= err_pend_d;
        end
    end

    assign rx_if.Rx_FlagDetect  = flag_q;
    assign rx_if.Rx_AbortDetect = abort_q;
    assign rx_if.Rx_ValidFrame  = valid_q;
    assign rx_if.Rx_Data        = data_q;
    assign rx_if.Rx_NewByte     = new_byte_q;
    assign rx_if.Rx_EoF         = eof_q;
    assign rx_if.Rx_FrameError  = err_q;
    assign rx_if.Rx_Overflow    = ovf_q;
    assign rx_if.Rx_FrameSize   = size_q;

endmodule

// File: tb/tb_hdlc_rx_deframer.sv
// Randomised bench for hdlc_rx_deframer: frames are built bit by bit and the
// expected event timeline is recorded at construction time.
module tb_hdlc_rx_deframer;

    localparam int MAXB = 4;
    localparam int NMAX = 16384;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    hdlc_rx_deframer_if bus();

    hdlc_rx_deframer #(.MAX_FRAME_BYTES(MAXB)) dut (
        .Clk   (clk),
        .Rst   (rst),
        .rx_if (bus)
    );

    int checks = 0;
    int errors = 0;

    bit         stream[$];
    bit         e_flag[NMAX];
    bit         e_abort[NMAX];
    bit         e_nb[NMAX];
    bit         e_eof[NMAX];
    bit         e_err[NMAX];
    bit         e_ovf[NMAX];
    bit         e_rise[NMAX];
    bit         e_fall[NMAX];
    bit         e_size_set[NMAX];
    bit         e_valid[NMAX];
    logic [7:0] e_data[NMAX];
    logic [7:0] e_size_val[NMAX];
    logic [7:0] e_sz[NMAX];

    int ones_run = 0;
    int n_bytes  = 0;
    int resid    = 0;
    bit opened   = 1'b0;
    bit last_abort = 1'b0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input bit en, input bit b);
        @(negedge clk);
        bus.RxEN = en;
        bus.Rx   = b;
        @(posedge clk);
        #1;
    endtask

    task automatic raw(input bit b);
        stream.push_back(b);
    endtask

    // Transmitter-side zero insertion after five consecutive data 1s.
    task automatic data_bit(input bit b);
        raw(b);
        if (b) begin
            ones_run++;
            if (ones_run == 5) begin
                raw(1'b0);
                ones_run = 0;
            end
        end else begin
            ones_run = 0;
        end
    endtask

    task automatic close_frame(input int t, input bit is_flag);
        if (n_bytes > 0) begin
            e_fall[t + 1] = 1'b1;
            e_eof[t + 2]  = 1'b1;
            e_err[t + 2]  = is_flag && (resid != 0);
        end
    endtask

    task automatic send_flag();
        int t;
        raw(1'b0);
        repeat (6) raw(1'b1);
        raw(1'b0);
        t = stream.size() - 1;
        e_flag[t + 1] = 1'b1;
        if (opened) close_frame(t, 1'b1);
        opened     = 1'b1;
        n_bytes    = 0;
        resid      = 0;
        ones_run   = 0;
        last_abort = 1'b0;
    endtask

    task automatic send_abort();
        int t;
        raw(1'b0);
        repeat (7) raw(1'b1);
        t = stream.size() - 1;
        e_abort[t + 1] = 1'b1;
        if (opened) close_frame(t, 1'b0);
        opened     = 1'b0;
        n_bytes    = 0;
        resid      = 0;
        ones_run   = 0;
        last_abort = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] v);
        int s = 0;
        int k;
        for (int i = 0; i < 8; i++) begin
            if (i == 7) s = stream.size();
            data_bit(v[i]);
        end
        if (opened) begin
            n_bytes++;
            k = s + 8;
            if (n_bytes <= MAXB) begin
                e_nb[k]       = 1'b1;
                e_data[k]     = v;
                e_size_set[k] = 1'b1;
                e_size_val[k] = 8'(n_bytes);
                if (n_bytes == 1) e_rise[k] = 1'b1;
            end else if (n_bytes == MAXB + 1) begin
                e_ovf[k] = 1'b1;
            end
        end
    endtask

    task automatic send_partial(input int n);
        for (int i = 0; i < n; i++) data_bit(1'(($urandom_range(0, 1))));
        if (opened) resid = n;
    endtask

    function automatic logic [7:0] pick_byte();
        case ($urandom_range(0, 3))
            0:       return 8'hFF;
            1:       return 8'h7E;
            default: return 8'($urandom);
        endcase
    endfunction

    task automatic build_stream();
        int nb;
        int kind;
        int junk;
        bit vv = 1'b0;
        logic [7:0] sz = 8'd0;

        repeat (10) raw(1'b1);
        send_flag();
        send_byte(8'hA5);
        send_flag();
        send_byte(8'h3F);
        send_flag();
        send_byte(8'h12);
        send_byte(8'h34);
        send_abort();
        send_byte(8'h55);
        send_byte(8'hFF);
        send_flag();
        send_byte(8'hC3);
        send_partial(4);
        send_flag();
        for (int i = 0; i < 6; i++) send_byte(8'(i * 37 + 1));
        send_flag();

        for (int f = 0; f < 25; f++) begin
            nb = $urandom_range(0, 6);
            for (int i = 0; i < nb; i++) send_byte(pick_byte());
            kind = $urandom_range(0, 3);
            if (kind == 1) send_partial($urandom_range(1, 7));
            if (kind == 0) send_abort();
            else send_flag();

            if (last_abort) begin
                junk = $urandom_range(0, 2);
                for (int j = 0; j < junk; j++) send_byte(8'($urandom));
                if (junk == 0) repeat ($urandom_range(0, 9)) raw(1'b1);
                send_flag();
            end else if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(0, 5)) raw(1'b1);
                send_flag();
            end
        end
        send_abort();
        repeat (12) raw(1'b1);

        for (int k = 0; k < NMAX; k++) begin
            if (e_rise[k]) vv = 1'b1;
            if (e_fall[k]) vv = 1'b0;
            e_valid[k] = vv;
            if (e_size_set[k]) sz = e_size_val[k];
            e_sz[k] = sz;
        end
    endtask

    initial begin
        logic [6:0] ev_obs;
        logic [6:0] ev_exp;
        logic [7:0] a5;

        rst      = 1'b1;
        bus.RxEN = 1'b0;
        bus.Rx   = 1'b1;
        #1;
        ev_obs = {bus.Rx_FlagDetect, bus.Rx_AbortDetect, bus.Rx_NewByte, bus.Rx_EoF,
                  bus.Rx_FrameError, bus.Rx_Overflow, bus.Rx_ValidFrame};
        checkOutput("reset_events", 32'(ev_obs), 32'd0);
        checkOutput("reset_data", 32'(bus.Rx_Data), 32'd0);
        checkOutput("reset_size", 32'(bus.Rx_FrameSize), 32'd0);

        build_stream();
        $display("[TB] stream of %0d bits built", stream.size());

        @(negedge clk);
        rst = 1'b0;

        for (int k = 0; k < 12; k++) begin
            applyStimulus(1'b0, 1'(($urandom_range(0, 1))));
            ev_obs = {bus.Rx_FlagDetect, bus.Rx_AbortDetect, bus.Rx_NewByte, bus.Rx_EoF,
                      bus.Rx_FrameError, bus.Rx_Overflow, bus.Rx_ValidFrame};
            checkOutput($sformatf("disabled@%0d", k), 32'(ev_obs), 32'd0);
        end

        for (int k = 0; k < stream.size(); k++) begin
            applyStimulus(1'b1, stream[k]);
            ev_obs = {bus.Rx_FlagDetect, bus.Rx_AbortDetect, bus.Rx_NewByte, bus.Rx_EoF,
                      bus.Rx_FrameError, bus.Rx_Overflow, bus.Rx_ValidFrame};
            ev_exp = {e_flag[k], e_abort[k], e_nb[k], e_eof[k], e_err[k], e_ovf[k], e_valid[k]};
            checkOutput($sformatf("events@%0d", k), 32'(ev_obs), 32'(ev_exp));
            checkOutput($sformatf("size@%0d", k), 32'(bus.Rx_FrameSize), 32'(e_sz[k]));
            if (e_nb[k]) checkOutput($sformatf("data@%0d", k), 32'(bus.Rx_Data), 32'(e_data[k]));
        end

        a5 = 8'hA5;
        applyStimulus(1'b1, 1'b0);
        repeat (6) applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0);
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, a5[i]);
        repeat (8) applyStimulus(1'b1, 1'b0);
        checkOutput("pre_rst_valid", 32'(bus.Rx_ValidFrame), 32'd1);
        checkOutput("pre_rst_data", 32'(bus.Rx_Data), 32'hA5);
        checkOutput("pre_rst_size", 32'(bus.Rx_FrameSize), 32'd1);

        #3;
        rst = 1'b1;
        #1;
        ev_obs = {bus.Rx_FlagDetect, bus.Rx_AbortDetect, bus.Rx_NewByte, bus.Rx_EoF,
                  bus.Rx_FrameError, bus.Rx_Overflow, bus.Rx_ValidFrame};
        checkOutput("midrst_events", 32'(ev_obs), 32'd0);
        checkOutput("midrst_data", 32'(bus.Rx_Data), 32'd0);
        checkOutput("midrst_size", 32'(bus.Rx_FrameSize), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hdlc_rx_deframer.md
Name: hdlc_rx_deframer

Overview:
Bit-level front end of the HDLC receive channel. It takes the serial Rx line and detects flags (01111110) and aborts (0 followed by seven 1s). It removes stuffed zeros and assembles LSB-first data bytes. Its outputs are Rx_FlagDetect, Rx_AbortDetect, Rx_ValidFrame, Rx_EoF and per-byte writes, which feed the Rx buffer / status-register stage downstream.

Parameters:
MAX_FRAME_BYTES, 128, data bytes accepted per frame before overflow; legal range 1..255.

Ports:
Clk  input  1  system clock; all sampling on the rising edge.
Rst  input  1  asynchronous, active-high reset.
RxEN  input  1  receiver enable.
Rx  input  1  serial receive line, one bit per Clk.
Rx_FlagDetect  output  1  one-cycle pulse per detected flag.
Rx_AbortDetect  output  1  one-cycle pulse per detected abort pattern.
Rx_ValidFrame  output  1  high while a frame with at least one completed byte is open.
Rx_Data  output  8  last assembled byte; bit 0 is the first received bit.
Rx_NewByte  output  1  one-cycle strobe: Rx_Data is valid.
Rx_EoF  output  1  one-cycle pulse at frame end (closing flag or abort).
Rx_FrameError  output  1  one-cycle pulse, coincident with Rx_EoF, when the data bit count is not a multiple of 8.
Rx_Overflow  output  1  one-cycle pulse when byte MAX_FRAME_BYTES+1 completes.
Rx_FrameSize  output  8  bytes accepted in the current/last frame; saturates at MAX_FRAME_BYTES.

Behaviour:
- Reset (async, Rst=1): all outputs 0; 8-bit window shift register = 8'hFF (idle line); byte/bit/ones counters 0; FSM = IDLE.
- Window: at each Clk edge t with RxEN=1, the sampled Rx shifts into window bit 0, oldest at bit 7.
- Timing reference: "edge t" is the edge at which the last bit of a pattern is sampled from Rx.
- Flag: window = 0,1,1,1,1,1,1,0 (oldest first). Rx_FlagDetect is registered at edge t+1, so it is high in the cycle between t+1 and t+2 and reads 1 at edge t+2.
- Abort: 0 followed by seven 1s. Rx_AbortDetect follows the same timing (rises at t+1). A continuing run of 1s must not retrigger it.
- FSM states:
  - IDLE: flag -> OPEN.
  - OPEN (flag seen, no byte yet): bits processed; first completed byte -> FRAME. Flag -> OPEN; partial bits discarded, no EoF. Abort -> IDLE.
  - FRAME: flag -> OPEN with end-of-frame handling. Abort -> IDLE with end-of-frame handling.
- Data path: a window bit is processed when it leaves bit 7 (edge t+8 for a bit sampled at t). Bits belonging to a detected flag or abort are never processed as data.
- Zero removal: count consecutive processed 1s. A 0 that follows exactly five 1s is discarded, and the count is cleared on every 0.
- Byte assembly: 8 kept bits -> Rx_Data, Rx_NewByte=1 and Rx_FrameSize+1, all registered at the same edge that processes the 8th bit. Rx_ValidFrame rises with the first Rx_NewByte of a frame.
- End of frame (from FRAME): Rx_ValidFrame falls at edge t+1, and Rx_EoF pulses at edge t+2.
  - Closing flag: Rx_FrameError pulses with Rx_EoF if the residual bit count is nonzero.
  - Abort: Rx_FrameError=0.
  - Rx_FrameSize holds its value until the next frame's first byte, which resets it to 1.
- Overflow: when byte MAX_FRAME_BYTES+1 completes, pulse Rx_Overflow once and suppress further Rx_NewByte. Rx_FrameSize stays at MAX_FRAME_BYTES and the frame stays open until a flag or abort.
- Shared flag: a single flag closes one frame and opens the next.
- RxEN low: window frozen; FSM forced to IDLE; Rx_ValidFrame forced to 0 with no Rx_EoF. Detection pulses are not generated. Re-enable requires a fresh flag.
- Simultaneous events: flag and byte completion at the same edge cannot occur, because data bits are processed eight edges later. Abort overrides any pending EoF/FrameError of the same cycle.

Test Plan:
- Rx idle 1s, then 0111_1110 with last 0 at edge 100 -> Rx_FlagDetect reads 1 at edge 102 only; no other outputs.
- Flag, byte 8'hA5 sent LSB first, flag -> one Rx_NewByte with Rx_Data=8'hA5. Rx_ValidFrame falls one edge before Rx_EoF; Rx_FrameSize=1; Rx_FrameError=0.
- Flag, 8'h3F (bits 1,1,1,1,1,1,0,0 sent with a stuffed 0 after the fifth 1), flag -> Rx_Data=8'h3F; no flag or abort falsely detected.
- Flag, 2 bytes, 0 followed by seven 1s -> Rx_AbortDetect reads 1 at edge t+2; Rx_EoF pulses; Rx_FrameError=0; FSM returns to IDLE. Following bytes are ignored until a new flag.
- Flag, 12 data bits, flag -> one Rx_NewByte; Rx_EoF and Rx_FrameError both pulse.
- MAX_FRAME_BYTES=4: flag, 6 bytes, flag -> 4 Rx_NewByte; one Rx_Overflow on byte 5; Rx_FrameSize=4; Rx_EoF at close. Rst asserted mid-frame -> all outputs 0 immediately.
